// File: rtl/level_meter_if.sv
// Sample stream into the level meter: signed audio word plus its valid qualifier.
interface level_meter_if #(
  parameter int DATA_W = 16
);
  logic signed [DATA_W-1:0] data_in;
  logic                     data_valid;

  modport master (output data_in, data_valid);
  modport slave  (input  data_in, data_valid);
endinterface

// File: rtl/level_meter.sv
// Windowed peak bargraph meter with instant attack / one-LED-per-window release.
// Optional peak-hold dot compiled in with LEVEL_METER_PEAK_HOLD_EN.
//
// state  | meaning
// ACC    | accumulating max |sample| of the current window
// UPDATE | one cycle: convert peak to a level, register led and window_tick
module level_meter #(
  parameter int DATA_W        = 16,
  parameter int N_LEDS        = 16,
  parameter int WINDOW_CYCLES = 3000000,
  parameter int HOLD_WINDOWS  = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  level_meter_if.slave      smp,
  output logic [N_LEDS-1:0] led,
  output logic              window_tick
);

  localparam int LVL_W = $clog2(N_LEDS + 1);
  localparam int P_W   = DATA_W + LVL_W;
  localparam int CNT_W = $clog2(WINDOW_CYCLES);
  localparam int HC_W  = $clog2(HOLD_WINDOWS + 1);
  localparam logic [CNT_W-1:0] TC_VAL = CNT_W'(WINDOW_CYCLES - 1);

  if (DATA_W < 4 || DATA_W > 32 || N_LEDS < 2 || N_LEDS > 32 ||
      WINDOW_CYCLES < 2 || HOLD_WINDOWS < 1 || HC_W < 1) begin : g_param_check
    $error("level_meter: parameter out of range");
  end

  typedef enum logic {ACC = 1'b0, UPDATE = 1'b1} state_t;

  state_t             state_q, state_d;
  logic               upd;
  logic [CNT_W-1:0]   cnt_q;
  logic               tc;
  logic [DATA_W-1:0]  raw, mag;
  logic [DATA_W-1:0]  acc_q, acc_d;
  logic [P_W-1:0]     prod, scaled;
  logic [LVL_W-1:0]   new_level, bar_q, bar_d;
  logic [N_LEDS-1:0]  bar_led, led_d;

  assign raw = smp.data_in;
  assign tc  = (cnt_q == TC_VAL);

  // Two's-complement negate in unsigned DATA_W bits: the most-negative code maps to 2^(DATA_W-1).
  always_comb begin
    mag = raw;
    if (raw[DATA_W-1]) mag = ~raw + DATA_W'(1);
  end

  always_comb begin
    state_d = state_q;
    upd     = 1'b0;
    case (state_q)
      ACC:    if (tc) state_d = UPDATE;
      UPDATE: begin
        upd     = 1'b1;
        state_d = ACC;
      end
      default: state_d = ACC;
    endcase
  end

  always_comb begin
    acc_d = acc_q;
    if (upd) begin
      acc_d = smp.data_valid ? mag : '0;
    end else if (smp.data_valid && (mag > acc_q)) begin
      acc_d = mag;
    end
  end

  always_comb begin
    prod      = P_W'(acc_q) * P_W'(N_LEDS);
    scaled    = prod >> (DATA_W - 1);
    new_level = (scaled > P_W'(N_LEDS)) ? LVL_W'(N_LEDS) : scaled[LVL_W-1:0];
    bar_d     = (new_level >= bar_q) ? new_level : bar_q - LVL_W'(1);
    bar_led   = '0;
    for (int i = 0; i < N_LEDS; i++) bar_led[i] = (i < int'(bar_d));
  end

`ifdef LEVEL_METER_PEAK_HOLD_EN
  logic [LVL_W-1:0] hold_q, hold_d;
  logic [HC_W-1:0]  hcnt_q, hcnt_d;

  always_comb begin
    hold_d = hold_q;
    hcnt_d = hcnt_q;
    if (bar_d >= hold_q) begin
      hold_d = bar_d;
      hcnt_d = HC_W'(HOLD_WINDOWS);
    end else if (hcnt_q != '0) begin
      hcnt_d = hcnt_q - HC_W'(1);
    end else begin
      hold_d = hold_q - LVL_W'(1);
    end
    led_d = bar_led;
    for (int i = 0; i < N_LEDS; i++) begin
      if ((hold_d != '0) && (i == int'(hold_d) - 1)) led_d[i] = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_q <= '0;
      hcnt_q <= '0;
    end else if (upd) begin
      hold_q <= hold_d;
      hcnt_q <= hcnt_d;
    end
  end
`else
  always_comb led_d = bar_led;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ACC;
      cnt_q       <= '0;
      acc_q       <= '0;
      bar_q       <= '0;
      led         <= '0;
      window_tick <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= tc ? '0 : cnt_q + CNT_W'(1);
      acc_q       <= acc_d;
      window_tick <= upd;
      if (upd) begin
        bar_q <= bar_d;
        led   <= led_d;
      end
    end
  end

endmodule

// File: tb/tb_level_meter.sv
// Directed bench for level_meter with an 8-cycle window and 2-window peak hold.
module tb_level_meter;

  logic        clk;
  logic        rst_n;
  logic [15:0] led;
  logic        window_tick;
  int          n_checks;
  int          n_fail;

  level_meter_if #(.DATA_W(16)) smp_if ();

  level_meter #(
    .DATA_W(16), .N_LEDS(16), .WINDOW_CYCLES(8), .HOLD_WINDOWS(2)
  ) dut (
    .clk(clk), .rst_n(rst_n), .smp(smp_if), .led(led), .window_tick(window_tick)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] expv);
    n_checks++;
    if (got !== expv) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, expv, $time);
    end
  endtask

  // Drive one cycle from a falling edge; returns on the next falling edge.
  task automatic cycle(input logic [15:0] d, input logic v);
    smp_if.data_in    = d;
    smp_if.data_valid = v;
    @(negedge clk);
  endtask

  // One window aligned so i==0 is the UPDATE cycle (counter 0). Invalid cycles carry
  // full-scale data to prove that only qualified samples count.
  task automatic window(input logic [15:0] d, input int pos, input bit first,
                        input logic [15:0] exp_led);
    for (int i = 0; i < 8; i++) begin
      cycle((i == pos) ? d : 16'h8000, i == pos);
      check("window_tick", {31'b0, window_tick}, {31'b0, (i == 0) && !first});
      check("led", {16'b0, led}, {16'b0, exp_led});
    end
  endtask

  function automatic logic [15:0] therm(input int b);
    logic [16:0] t;
    t = (17'd1 << b) - 17'd1;
    return t[15:0];
  endfunction

  // Expected display while the bar decays from full scale in silence.
  function automatic logic [15:0] decay_led(input int b);
`ifdef LEVEL_METER_PEAK_HOLD_EN
    int h;
    h = (b + 2 > 16) ? 16 : b + 2;
    return therm(b) | (16'h0001 << (h - 1));
`else
    return therm(b);
`endif
  endfunction

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst_n    = 1'b0;
    smp_if.data_in    = '0;
    smp_if.data_valid = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_led", {16'b0, led}, 32'h0);
    check("reset_tick", {31'b0, window_tick}, 32'h0);
    rst_n = 1'b1;

    window(16'h4000, 3, 1'b1, 16'h0000);
    window(16'h0000, -1, 1'b0, 16'h00FF);
`ifdef LEVEL_METER_PEAK_HOLD_EN
    window(16'h8000, 5, 1'b0, 16'h00FF);
`else
    window(16'h8000, 5, 1'b0, 16'h007F);
`endif
    for (int b = 16; b >= 0; b--) begin
      if (b == 0) window(16'h7FFF, 4, 1'b0, decay_led(b));
      else        window(16'h0000, -1, 1'b0, decay_led(b));
    end
    window(16'h8000, 6, 1'b0, 16'h7FFF);

    // Asynchronous reset in the middle of a full-scale window.
    cycle(16'h0000, 1'b0);
    check("pre_reset_led", {16'b0, led}, 32'h0000FFFF);
    check("pre_reset_tick", {31'b0, window_tick}, 32'h1);
    cycle(16'h0000, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    check("async_reset_led", {16'b0, led}, 32'h0);
    repeat (2) @(negedge clk);
    check("held_reset_led", {16'b0, led}, 32'h0);
    rst_n = 1'b1;

    window(16'h2000, 7, 1'b1, 16'h0000);
    window(16'h6000, 0, 1'b0, 16'h000F);
    window(16'h0000, -1, 1'b0, 16'h0FFF);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/level_meter.md
LEVEL_METER -- requirements
Module: level_meter

Interface
REQ-001 Parameter DATA_W, default 16, signed two's-complement sample width (4..32).
REQ-002 Parameter N_LEDS, default 16, bargraph LED count (2..32).
REQ-003 Parameter WINDOW_CYCLES, default 3000000, clk cycles per display window (>=2).
REQ-004 Parameter HOLD_WINDOWS, default 8, windows a peak-hold dot stays before falling (>=1).
REQ-005 Port clk  input  1  board clock, all logic rising-edge.
REQ-006 Port rst_n  input  1  asynchronous, active-low reset.
REQ-007 Port data_in  input  DATA_W  signed audio sample.
REQ-008 Port data_valid  input  1  data_in qualifier, sampled on clk rising edge when high.
REQ-009 Port led  output  N_LEDS  bargraph, bit 0 = lowest segment.
REQ-010 Port window_tick  output  1  one-cycle pulse when led updates.

Function
REQ-011 Magnitude: mag = |data_in| as unsigned DATA_W bits; most-negative input maps to 2^(DATA_W-1), no overflow.
REQ-012 Window counter counts 0..WINDOW_CYCLES-1, wraps to 0; terminal count is the window end.
REQ-013 Accumulator holds max mag of valid samples in the current window; invalid cycles leave it unchanged.
REQ-014 FSM states ACC (accumulating) and UPDATE (one cycle); ACC->UPDATE on terminal count, UPDATE->ACC unconditionally.
REQ-015 Sample valid on the terminal-count cycle is included in the ending window; sample valid during UPDATE seeds the new window accumulator (no sample lost).
REQ-016 In UPDATE: new_level = min(N_LEDS, (peak*N_LEDS) >> (DATA_W-1)), computed at full product width, no truncation.
REQ-017 Ballistics: if new_level >= bar_level then bar_level = new_level (instant attack), else bar_level decrements by exactly 1 (slow release).
REQ-018 led bits [bar_level-1:0] set, rest clear; bar_level 0 gives all-zero led.
REQ-019 led and window_tick register in UPDATE; window_tick high for exactly that one cycle; led stable between updates.
REQ-020 Accumulator clears to 0 (or to mag of a concurrent valid sample) at end of UPDATE.
REQ-021 Latency: window end to led change is 2 clk cycles.

Reset
REQ-022 rst_n low asynchronously clears led, window_tick, bar_level, accumulator, counter, hold state; FSM to ACC.
REQ-023 Reset mid-window discards the partial window; first update after release occurs WINDOW_CYCLES+1 cycles after the first clk edge with rst_n high.

Configuration
REQ-024 Macro LEVEL_METER_PEAK_HOLD_EN compiles in peak-hold; absent, led is exactly the bar of REQ-018.
REQ-025 With macro: hold_level tracks max bar_level; on new max it reloads and resets a hold counter to HOLD_WINDOWS.
REQ-026 With macro: hold counter decrements per UPDATE; at 0 hold_level decrements by 1 per window until equal to bar_level.
REQ-027 With macro: led = bar OR bit (hold_level-1) when hold_level > 0; hold dot lights nothing extra when hold_level == bar_level.

Verification (DATA_W=16, N_LEDS=16, WINDOW_CYCLES=8, HOLD_WINDOWS=2)
REQ-028 Single valid sample 0x4000 in window -> led=16'h00FF, window_tick once per 8 cycles.
REQ-029 Sample 0x8000 (-32768) -> led=16'hFFFF; sample 0x7FFF -> led=16'h7FFF (level 15).
REQ-030 Full scale one window, then silence -> led 16'hFFFF,7FFF,3FFF,... one bit per window to 0.
REQ-031 Valid samples on terminal-count and UPDATE cycles, 0x2000 then 0x6000 -> first window level 4 (16'h000F), second window level 12 (16'h0FFF).
REQ-032 rst_n asserted mid-window with led=16'hFFFF -> led=0 immediately, no window_tick until 9 cycles after release.
REQ-033 Macro defined, full scale then silence -> hold bit 15 stays set 2 windows above falling bar, then steps down one per window.
